rgmii_tx_sched: RTL and testbench

- Transmit-side byte scheduler between the UDP/MAC byte stream and the per-bit ODDR primitives driving the RGMII TXD[3:0]/TX_CTL pins.
- Frames the byte stream:
  - inserts preamble and SFD;
  - pads short frames to the Ethernet minimum;
  - enforces inter-frame gap;
  - splits each byte into rising and falling nibbles (d0/d1) for the ODDRs.
- Runs entirely in the 125 MHz TX clock domain.

---
 rtl/rgmii_pkg.sv | 30 +++
 rtl/crc32_d8.sv | 24 ++
 rtl/rgmii_tx_sched.sv | 193 +++++++++++++++++++
 tb/tb_rgmii_tx_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// Shared state encoding and framing/CRC constants for the RGMII transmit scheduler.
package rgmii_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      DATA,
      PAD,
      FCS,
      IFG
   } tx_state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
   localparam logic [10:0] LEN_MAX       = 11'h7FF;

   // Ethernet shifts LSB first, so the CRC register runs on the bit-reversed polynomial.
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-parallel next-state function of the reflected Ethernet CRC-32.
// Purely combinational; the unrolled loop collapses into an XOR tree.
module crc32_d8
   import rgmii_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_out[0] ^ data[i]) begin
            crc_out = (crc_out >> 1) ^ POLY_REFL;
         end else begin
            crc_out = crc_out >> 1;
         end
      end
   end

endmodule

// File: rtl/rgmii_tx_sched.sv
// RGMII TX byte scheduler: preamble/SFD insertion, short-frame padding, IFG and nibble split.
// Define RGMII_TX_FCS_EN to compute and append the CRC-32 FCS in hardware.
module rgmii_tx_sched
   import rgmii_pkg::*;
#(
   parameter int IFG_BYTES      = 12,
   parameter int MIN_FRAME      = 60,
   parameter int PREAMBLE_BYTES = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [3:0] txd_d0,
   output logic [3:0] txd_d1,
   output logic       txctl_d0,
   output logic       txctl_d1,
   output logic       busy,
   output logic       underrun
);

   localparam int                CNT_W    = 8;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PREAMBLE_BYTES);
   localparam logic [CNT_W-1:0]  IFG_LAST = CNT_W'(IFG_BYTES - 1);
   localparam logic [11:0]       MIN_LEN  = 12'(MIN_FRAME);
`ifdef RGMII_TX_FCS_EN
   localparam tx_state_e         END_STATE = FCS;
`else
   localparam tx_state_e         END_STATE = IFG;
`endif

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [10:0]      len_cnt_q, len_cnt_d;
   logic [10:0]      len_sat;
   logic [11:0]      len_next;

   logic [7:0]       tx_byte_d;
   logic             tx_en_d;
   logic             tx_er_d;
   logic             underrun_d;

   logic [3:0]       txd_d0_q, txd_d1_q;
   logic             txctl_d0_q, txctl_d1_q;
   logic             underrun_q;

   assign len_next = {1'b0, len_cnt_q} + 12'd1;
   assign len_sat  = (len_cnt_q == LEN_MAX) ? len_cnt_q : len_cnt_q + 11'd1;

`ifdef RGMII_TX_FCS_EN
   logic [31:0] crc_q, crc_d, crc_next, fcs_word;

   crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (tx_byte_d),
      .crc_out (crc_next)
   );

   assign fcs_word = ~crc_q;

   // The CRC covers exactly the bytes sent in DATA and PAD; pad bytes are zero.
   always_comb begin
      crc_d = crc_q;
      if (state_q == IDLE) begin
         crc_d = CRC_INIT;
      end else if ((state_q == DATA && s_valid) || state_q == PAD) begin
         crc_d = crc_next;
      end
   end
`endif

   // IDLE already schedules the first preamble byte so the pin gap equals IFG_BYTES exactly.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_cnt_d  = len_cnt_q;
      tx_byte_d  = 8'h00;
      tx_en_d    = 1'b0;
      tx_er_d    = 1'b0;
      underrun_d = 1'b0;

      case (state_q)
         IDLE, PRE: begin
            if (state_q == IDLE) begin
               len_cnt_d = '0;
            end
            if (state_q == PRE || s_valid) begin
               tx_en_d = 1'b1;
               if (cnt_q >= PRE_LAST) begin
                  tx_byte_d = SFD_BYTE;
                  state_d   = DATA;
                  cnt_d     = '0;
               end else begin
                  tx_byte_d = PREAMBLE_BYTE;
                  state_d   = PRE;
                  cnt_d     = cnt_q + CNT_ONE;
               end
            end
         end

         DATA: begin
            tx_en_d = 1'b1;
            cnt_d   = '0;
            if (s_valid) begin
               tx_byte_d = s_data;
               len_cnt_d = len_sat;
               if (s_last) begin
                  state_d = (len_next < MIN_LEN) ? PAD : END_STATE;
               end
            end else begin
               tx_er_d    = 1'b1;
               underrun_d = 1'b1;
               state_d    = IFG;
            end
         end

         PAD: begin
            tx_en_d   = 1'b1;
            len_cnt_d = len_sat;
            if (len_next >= MIN_LEN) begin
               state_d = END_STATE;
               cnt_d   = '0;
            end
         end

`ifdef RGMII_TX_FCS_EN
         FCS: begin
            tx_en_d   = 1'b1;
            tx_byte_d = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
            cnt_d     = cnt_q + CNT_ONE;
            if (cnt_q[1:0] == 2'd3) begin
               state_d = IFG;
               cnt_d   = '0;
            end
         end
`endif

         IFG: begin
            if (cnt_q >= IFG_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         len_cnt_q  <= '0;
         txd_d0_q   <= '0;
         txd_d1_q   <= '0;
         txctl_d0_q <= 1'b0;
         txctl_d1_q <= 1'b0;
         underrun_q <= 1'b0;
`ifdef RGMII_TX_FCS_EN
         crc_q      <= CRC_INIT;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_cnt_q  <= len_cnt_d;
         txd_d0_q   <= tx_en_d ? tx_byte_d[3:0] : 4'h0;
         txd_d1_q   <= tx_en_d ? tx_byte_d[7:4] : 4'h0;
         txctl_d0_q <= tx_en_d;
         txctl_d1_q <= tx_en_d ^ tx_er_d;
         underrun_q <= underrun_d;
`ifdef RGMII_TX_FCS_EN
         crc_q      <= crc_d;
`endif
      end
   end

   assign s_ready  = (state_q == DATA);
   assign busy     = (state_q != IDLE);
   assign txd_d0   = txd_d0_q;
   assign txd_d1   = txd_d1_q;
   assign txctl_d0 = txctl_d0_q;
   assign txctl_d1 = txctl_d1_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_rgmii_tx_sched.sv
// Directed bench for rgmii_tx_sched: frame table plus back-to-back, underrun and mid-frame reset sequences.
module tb_rgmii_tx_sched;

   localparam int IFG_N   = 12;
   localparam int MIN_N   = 60;
   localparam int PRE_N   = 7;
   localparam int REC_MAX = 8192;
`ifdef RGMII_TX_FCS_EN
   localparam int FCS_EXTRA = 4;
`else
   localparam int FCS_EXTRA = 0;
`endif

   typedef struct {
      int         len;
      logic [7:0] base;
      int         en_cycles;
   } frame_vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic [3:0] txd_d0, txd_d1;
   logic       txctl_d0, txctl_d1, busy, underrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] rec_byte [REC_MAX];
   logic       rec_en   [REC_MAX];
   logic       rec_ctl1 [REC_MAX];
   logic       rec_urun [REC_MAX];
   logic       rec_busy [REC_MAX];
   logic       rec_rdy  [REC_MAX];
   int         rec_n = 0;

   frame_vec_t vecs [5];

   always #4 clk = ~clk;

   rgmii_tx_sched #(
      .IFG_BYTES      (IFG_N),
      .MIN_FRAME      (MIN_N),
      .PREAMBLE_BYTES (PRE_N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .txd_d0   (txd_d0),
      .txd_d1   (txd_d1),
      .txctl_d0 (txctl_d0),
      .txctl_d1 (txctl_d1),
      .busy     (busy),
      .underrun (underrun)
   );

   // Pin recorder, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (rec_n < REC_MAX) begin
         rec_byte[rec_n] <= {txd_d1, txd_d0};
         rec_en[rec_n]   <= txctl_d0;
         rec_ctl1[rec_n] <= txctl_d1;
         rec_urun[rec_n] <= underrun;
         rec_busy[rec_n] <= busy;
         rec_rdy[rec_n]  <= s_ready;
         rec_n           <= rec_n + 1;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   function automatic logic [7:0] exp_byte(input int k, input int len, input logic [7:0] base, input logic [31:0] fcs);
      int body;
      body = (len < MIN_N) ? MIN_N : len;
      if (k < PRE_N) return 8'h55;
      if (k == PRE_N) return 8'hD5;
      if (k < PRE_N + 1 + len) return base + 8'(k - PRE_N - 1);
      if (k < PRE_N + 1 + body) return 8'h00;
      if (k < PRE_N + 1 + body + 4) return 8'(fcs >> (8 * (k - PRE_N - 1 - body)));
      return 8'h00;
   endfunction

   task automatic applyStimulus(input int len, input logic [7:0] base, input bit last_flag, input bit drop);
      int t;
      for (int i = 0; i < len; i++) begin
         s_data  = base + 8'(i);
         s_last  = last_flag && (i == len - 1);
         s_valid = 1'b1;
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!s_ready && t < 200);
         if (!s_ready) begin
            checkOutput("ready_wait", 32'(s_ready), 32'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      s_last = 1'b0;
      if (drop) s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (busy && t < 1000);
      checkOutput("idle_reached", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic find_run(input int from, output int first, output int len);
      first = -1;
      len   = 0;
      for (int i = from; i < rec_n; i++) begin
         if (rec_en[i] && first < 0) first = i;
      end
      if (first >= 0) begin
         for (int i = first; i < rec_n && rec_en[i]; i++) len++;
      end
   endtask

   task automatic check_frame(input int start, input int len, input logic [7:0] base, input int en_exp, input string tag);
      int          first, run, bad, fall, body;
      logic [31:0] crc, fcs;
      find_run(start, first, run);
      if (first < 0) first = start;
      checkOutput({tag, "_en_cycles"}, 32'(run), 32'(en_exp));
      body = (len < MIN_N) ? MIN_N : len;
      crc  = 32'hFFFFFFFF;
      for (int k = PRE_N + 1; k < PRE_N + 1 + body; k++) crc = crc_step(crc, exp_byte(k, len, base, 32'h0));
      fcs = ~crc;
      bad = 0;
      for (int k = 0; k < run; k++) begin
         if (rec_byte[first+k] !== exp_byte(k, len, base, fcs) || rec_ctl1[first+k] !== 1'b1) bad++;
      end
      checkOutput({tag, "_bad_bytes"}, 32'(bad), 32'd0);
      fall = first + run;
      while (fall < rec_n && rec_busy[fall]) fall++;
      checkOutput({tag, "_busy_fall"}, 32'(fall - (first + run - 1)), 32'(IFG_N));
`ifdef RGMII_TX_FCS_EN
      crc = 32'hFFFFFFFF;
      for (int k = PRE_N + 1; k < run; k++) crc = crc_step(crc, rec_byte[first+k]);
      checkOutput({tag, "_crc_residue"}, crc, 32'hDEBB20E3);
`endif
   endtask

   initial begin
      int start, f1, r1, f2, r2, cnt, t;

      vecs[0] = '{64, 8'h00, 72};
      vecs[1] = '{10, 8'hA0, 68};
      vecs[2] = '{60, 8'h00, 68};
      vecs[3] = '{61, 8'h10, 69};
      vecs[4] = '{1,  8'h7E, 68};

      $display("[TB] reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_outputs",
                  32'({txd_d0, txd_d1, txctl_d0, txctl_d1, busy, underrun, s_ready}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] frame table");
      for (int v = 0; v < 5; v++) begin
         start = rec_n;
         applyStimulus(vecs[v].len, vecs[v].base, 1'b1, 1'b1);
         wait_idle();
         check_frame(start, vecs[v].len, vecs[v].base, vecs[v].en_cycles + FCS_EXTRA,
                     $sformatf("vec%0d", v));
      end

      $display("[TB] back-to-back frames");
      start = rec_n;
      applyStimulus(64, 8'h20, 1'b1, 1'b0);
      applyStimulus(64, 8'h60, 1'b1, 1'b1);
      wait_idle();
      find_run(start, f1, r1);
      if (f1 < 0) f1 = start;
      find_run(f1 + r1, f2, r2);
      if (f2 < 0) f2 = f1 + r1;
      checkOutput("b2b_len1", 32'(r1), 32'(72 + FCS_EXTRA));
      checkOutput("b2b_len2", 32'(r2), 32'(72 + FCS_EXTRA));
      checkOutput("b2b_gap", 32'(f2 - (f1 + r1)), 32'(IFG_N));
      cnt = 0;
      for (int i = f1 + r1; i < f2; i++) if (rec_rdy[i]) cnt++;
      checkOutput("b2b_ready_in_gap", 32'(cnt), 32'd0);

      $display("[TB] underrun");
      start = rec_n;
      applyStimulus(20, 8'h40, 1'b0, 1'b1);
      wait_idle();
      find_run(start, f1, r1);
      if (f1 < 0) f1 = start;
      checkOutput("urun_en_cycles", 32'(r1), 32'd29);
      checkOutput("urun_ctl1", 32'(rec_ctl1[f1+28]), 32'd0);
      checkOutput("urun_byte", 32'(rec_byte[f1+28]), 32'd0);
      checkOutput("urun_flag", 32'(rec_urun[f1+28]), 32'd1);
      checkOutput("urun_last_data", 32'(rec_byte[f1+27]), 32'h53);
      cnt = 0;
      for (int i = start; i < rec_n; i++) if (rec_urun[i]) cnt++;
      checkOutput("urun_pulses", 32'(cnt), 32'd1);
      cnt = 0;
      for (int i = f1 + 28; i < rec_n; i++) if (rec_rdy[i]) cnt++;
      checkOutput("urun_ready_after", 32'(cnt), 32'd0);

      $display("[TB] reset in DATA");
      s_data  = 8'h33;
      s_last  = 1'b0;
      s_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!s_ready && t < 200);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mid_reset_outputs",
                  32'({txd_d0, txd_d1, txctl_d0, txctl_d1, underrun, s_ready}), 32'd0);
      checkOutput("mid_reset_busy", 32'(busy), 32'd0);
      rst     = 1'b1;
      s_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = rec_n;
      applyStimulus(60, 8'h80, 1'b1, 1'b1);
      wait_idle();
      check_frame(start, 60, 8'h80, 68 + FCS_EXTRA, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
